bp_be_fma_wb_buffer: RTL and testbench

BP_BE_FMA_WB_BUFFER -- requirements
Module: bp_be_fma_wb_buffer

---
 rtl/bp_be_fma_wb_buffer_pkg.sv | 29 ++
 rtl/bp_be_fma_wb_buffer_if.sv | 29 ++
 rtl/bp_be_fma_wb_buffer_fifo.sv | 73 +++++++
 rtl/bp_be_fma_wb_buffer.sv | 116 +++++++++++
 tb/tb_bp_be_fma_wb_buffer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_fma_wb_buffer_pkg.sv
// Shared types for the FMA writeback buffer.
//   bp_params_e          : processor configuration selector
//   bp_be_fp_reg_s       : recoded FP register value (sp/dp tag + 65-bit recoded word)
//   bp_be_fma_wb_entry_s : one buffered FMA result {data, fflags, rd}
//   safe_clog2           : pointer width helper that never returns 0
package bp_be_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   localparam int dpath_width_gp = 64;

   typedef struct packed {
      logic                    sp_not_dp;
      logic [dpath_width_gp:0] rec;
   } bp_be_fp_reg_s;

   typedef struct packed {
      bp_be_fp_reg_s data;
      logic [4:0]    fflags;
      logic [4:0]    rd;
   } bp_be_fma_wb_entry_s;

   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_be_fma_wb_buffer_if.sv
// Result and writeback channels of the FMA writeback buffer.
//   fma_v_i/fma_data_i/fma_fflags_i/fma_rd_i : result from the FMA pipe
//   wb_v_o/wb_data_o/wb_fflags_o/wb_rd_o     : head entry toward the register file
//   wb_yumi_i                                : consumer takes the head entry
// modport master : the buffer side; modport slave : pipe plus consumer side.
interface bp_be_fma_wb_buffer_if;
   import bp_be_pkg::*;

   logic          fma_v_i;
   bp_be_fp_reg_s fma_data_i;
   logic [4:0]    fma_fflags_i;
   logic [4:0]    fma_rd_i;

   logic          wb_v_o;
   bp_be_fp_reg_s wb_data_o;
   logic [4:0]    wb_fflags_o;
   logic [4:0]    wb_rd_o;
   logic          wb_yumi_i;

   modport master (
      input  fma_v_i, fma_data_i, fma_fflags_i, fma_rd_i, wb_yumi_i,
      output wb_v_o, wb_data_o, wb_fflags_o, wb_rd_o
   );

   modport slave (
      output fma_v_i, fma_data_i, fma_fflags_i, fma_rd_i, wb_yumi_i,
      input  wb_v_o, wb_data_o, wb_fflags_o, wb_rd_o
   );
endinterface

// File: rtl/bp_be_fma_wb_buffer_fifo.sv
// bsg_fifo_1r1w_small: small registered-output FIFO holding FMA results.
//   clk_i, reset_n_i : clock, async active-low reset (pointers/count only)
//   clear_i          : empty the FIFO; same-cycle push and pop are ignored
//   v_i, data_i      : push
//   v_o, data_o      : head entry (written data is visible the cycle after the push)
//   yumi_i           : pop the head
//   count_o          : occupancy
module bsg_fifo_1r1w_small
   import bp_be_pkg::*;
#(
   parameter int els_p   = 2,
   parameter int width_p = 8,
   localparam int cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                clear_i,
   input  logic                v_i,
   input  logic [width_p-1:0]  data_i,
   output logic                v_o,
   output logic [width_p-1:0]  data_o,
   input  logic                yumi_i,
   output logic [cnt_w_lp-1:0] count_o
);
   localparam int ptr_w_lp = safe_clog2(els_p);

   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] rptr, wptr;
   logic [cnt_w_lp-1:0] count;
   logic                enq, deq;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign enq = v_i & ~clear_i;
   assign deq = yumi_i & ~clear_i;

   // Storage is not reset; data_o is meaningless while v_o is low.
   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (clear_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (enq) wptr <= ptr_inc(wptr);
         if (deq) rptr <= ptr_inc(rptr);
         case ({enq, deq})
            2'b10:   count <= count + cnt_w_lp'(1);
            2'b01:   count <= count - cnt_w_lp'(1);
            default: count <= count;
         endcase
      end
   end

   assign v_o     = (count != '0);
   assign data_o  = mem[rptr];
   assign count_o = count;

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (enq && !deq) |-> (count != cnt_w_lp'(els_p)))
      else $error("push into full fifo");

endmodule

// File: rtl/bp_be_fma_wb_buffer.sv
// bp_be_fma_wb_buffer: reorders nothing, drops flushed results and holds FMA
// results until the writeback consumer takes them.
//   clk_i, reset_n_i        : clock, async active-low reset
//   issue_v_i/issue_ready_o : dispatch of an op into the FMA pipe / room for one more
//   flush_i                 : kill every in-flight and buffered result
//   bus (master)            : FMA result in, head entry out, wb_yumi_i pop
//   fflags_acc_o            : sticky OR of retired flags; fflags_clr_i clears it
// Optional feature: define BP_BE_FMA_WB_FFLAGS_ACC_EN to build the flag
// accumulator; otherwise fflags_acc_o is tied to 0 and fflags_clr_i is ignored.
module bp_be_fma_wb_buffer
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p   = e_bp_default_cfg,
   parameter int         fma_latency_p = 4,
   parameter int         depth_p       = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  issue_v_i,
   output logic                  issue_ready_o,
   input  logic                  flush_i,
   bp_be_fma_wb_buffer_if.master bus,
   output logic [4:0]            fflags_acc_o,
   input  logic                  fflags_clr_i
);
   localparam int occ_w_lp      = $clog2(depth_p + 1);
   localparam int inflight_w_lp = $clog2(fma_latency_p + 1);

   if (fma_latency_p < 2) begin : g_bad_latency
      $error("fma_latency_p must be at least 2");
   end
   if (depth_p < 1) begin : g_bad_depth
      $error("depth_p must be at least 1");
   end
   if (bp_params_p != e_bp_default_cfg) begin : g_bad_cfg
      $error("unsupported bp_params_p");
   end

   // One bit per pipe stage: set when the op in that stage is still wanted.
   // The tail bit qualifies the result leaving the pipe this cycle.
   logic [fma_latency_p-1:0] live;
   logic [inflight_w_lp-1:0] inflight;
   logic [occ_w_lp-1:0]      occ;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)   live <= '0;
      else if (flush_i) live <= '0;
      else              live <= {live[fma_latency_p-2:0], issue_v_i};
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < fma_latency_p; i++) begin
         inflight = inflight + inflight_w_lp'(live[i]);
      end
   end

   // Every op already in the pipe has a reserved slot, so the FIFO can never
   // overflow as long as issue respects this.
   assign issue_ready_o = (int'(occ) + int'(inflight)) < depth_p;

   bp_be_fma_wb_entry_s enq_entry, head_entry;
   logic                enq_v, head_v;

   assign enq_v     = bus.fma_v_i & live[fma_latency_p-1];
   assign enq_entry = '{data: bus.fma_data_i, fflags: bus.fma_fflags_i, rd: bus.fma_rd_i};

   bsg_fifo_1r1w_small #(
      .els_p   (depth_p),
      .width_p ($bits(bp_be_fma_wb_entry_s))
   ) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (flush_i),
      .v_i       (enq_v),
      .data_i    (enq_entry),
      .v_o       (head_v),
      .data_o    (head_entry),
      .yumi_i    (bus.wb_yumi_i),
      .count_o   (occ)
   );

   assign bus.wb_v_o      = head_v;
   assign bus.wb_data_o   = head_entry.data;
   assign bus.wb_fflags_o = head_entry.fflags;
   assign bus.wb_rd_o     = head_entry.rd;

`ifdef BP_BE_FMA_WB_FFLAGS_ACC_EN
   logic [4:0] acc;
   logic       deq;

   assign deq = bus.wb_yumi_i & head_v & ~flush_i;

   // Clear and retire in the same cycle keep only the retiring flags.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)        acc <= '0;
      else if (deq)          acc <= fflags_clr_i ? head_entry.fflags : (acc | head_entry.fflags);
      else if (fflags_clr_i) acc <= '0;
   end

   assign fflags_acc_o = acc;
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = fflags_clr_i;
   assign fflags_acc_o      = '0;
`endif

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      issue_v_i |-> issue_ready_o)
      else $error("issue while not ready");

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      bus.wb_yumi_i |-> bus.wb_v_o)
      else $error("yumi without valid head");

endmodule

// File: tb/tb_bp_be_fma_wb_buffer.sv
module tb_bp_be_fma_wb_buffer;
   import bp_be_pkg::*;

   localparam int lat_lp   = 4;
   localparam int depth_lp = 2;
`ifdef BP_BE_FMA_WB_FFLAGS_ACC_EN
   localparam bit acc_en_lp = 1'b1;
`else
   localparam bit acc_en_lp = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       reset_n_i = 1'b1;
   logic       issue_v_i, issue_ready_o, flush_i, fflags_clr_i;
   logic [4:0] fflags_acc_o;

   bp_be_fma_wb_buffer_if bus ();

   bp_be_fma_wb_buffer #(
      .bp_params_p   (e_bp_default_cfg),
      .fma_latency_p (lat_lp),
      .depth_p       (depth_lp)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .issue_v_i     (issue_v_i),
      .issue_ready_o (issue_ready_o),
      .flush_i       (flush_i),
      .bus           (bus),
      .fflags_acc_o  (fflags_acc_o),
      .fflags_clr_i  (fflags_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: every issued op travels through an ideal pipe and
   // emerges lat_lp cycles later; it lands in the expected buffer only if no
   // flush or reset happened meanwhile.
   typedef struct {
      int                  due;
      bit                  live;
      bp_be_fma_wb_entry_s e;
   } op_t;

   op_t                 pipe_q[$];
   bp_be_fma_wb_entry_s exp_q[$];
   logic [4:0]          acc_exp;
   bp_be_fma_wb_entry_s issue_e;
   int                  cyc;
   int                  errors;
   int                  checks;

   function automatic int live_cnt();
      int n = 0;
      foreach (pipe_q[i]) if (pipe_q[i].live) n++;
      return n;
   endfunction

   function automatic logic exp_ready();
      return (exp_q.size() + live_cnt()) < depth_lp;
   endfunction

   function automatic logic [4:0] exp_acc();
      return acc_en_lp ? acc_exp : 5'b0;
   endfunction

   function automatic bp_be_fma_wb_entry_s mk_entry(input logic [64:0] rec, input logic [4:0] f,
                                                    input logic [4:0] rd);
      bp_be_fma_wb_entry_s e;
      e.data.sp_not_dp = 1'b0;
      e.data.rec       = rec;
      e.fflags         = f;
      e.rd             = rd;
      return e;
   endfunction

   function automatic bp_be_fma_wb_entry_s rand_entry();
      bp_be_fma_wb_entry_s e;
      e.data.sp_not_dp = 1'($urandom);
      e.data.rec       = {1'($urandom), $urandom, $urandom};
      e.fflags         = 5'($urandom);
      e.rd             = 5'($urandom);
      return e;
   endfunction

   function automatic void model_kill();
      exp_q.delete();
      foreach (pipe_q[i]) pipe_q[i].live = 1'b0;
   endfunction

   // Advance one clock: present the pipe output, update the model from the
   // inputs set for this cycle, then step past the edge.
   task automatic tick();
      bit                  arrive;
      bp_be_fma_wb_entry_s junk;
      arrive = (pipe_q.size() > 0) && (pipe_q[0].due == cyc);
      junk   = rand_entry();
      bus.fma_v_i      = arrive;
      bus.fma_data_i   = arrive ? pipe_q[0].e.data   : junk.data;
      bus.fma_fflags_i = arrive ? pipe_q[0].e.fflags : junk.fflags;
      bus.fma_rd_i     = arrive ? pipe_q[0].e.rd     : junk.rd;

      if (!reset_n_i) acc_exp = 5'b0;
      else if (!flush_i && bus.wb_yumi_i && exp_q.size() > 0)
         acc_exp = fflags_clr_i ? exp_q[0].fflags : (acc_exp | exp_q[0].fflags);
      else if (fflags_clr_i) acc_exp = 5'b0;

      if (flush_i || !reset_n_i) model_kill();
      else begin
         if (bus.wb_yumi_i && exp_q.size() > 0) void'(exp_q.pop_front());
         if (arrive && pipe_q[0].live) exp_q.push_back(pipe_q[0].e);
      end
      if (arrive) void'(pipe_q.pop_front());
      if (issue_v_i) pipe_q.push_back('{due: cyc + lat_lp, live: (!flush_i && reset_n_i), e: issue_e});

      @(posedge clk_i);
      #1;
      cyc++;
      issue_v_i     = 1'b0;
      flush_i       = 1'b0;
      fflags_clr_i  = 1'b0;
      bus.wb_yumi_i = 1'b0;
      bus.fma_v_i   = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset_n_i = 1'b0;
      model_kill();
      acc_exp = 5'b0;
      #1;
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL reset_wb_v: got %b want 0", bus.wb_v_o); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
      checks++; if (fflags_acc_o !== 5'b0) begin errors++; $display("FAIL reset_acc: got %b want 0", fflags_acc_o); end
      tick();
      tick();
      reset_n_i = 1'b1;
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL post_reset_wb_v: got %b want 0", bus.wb_v_o); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", issue_ready_o); end
   endtask

   task automatic test_single();
      issue_e = mk_entry(65'h3FF0_0000_0000_0000, 5'b00001, 5'd3);
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_t0: got %b want 1", issue_ready_o); end
      issue_v_i = 1'b1;
      tick();
      for (int k = 1; k <= 4; k++) begin
         checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL single_wb_v_t%0d: got %b want 0", k, bus.wb_v_o); end
         tick();
      end
      checks++; if (bus.wb_v_o !== 1'b1) begin errors++; $display("FAIL single_wb_v_t5: got %b want 1", bus.wb_v_o); end
      checks++; if (bus.wb_data_o.rec !== 65'h3FF0_0000_0000_0000)
         begin errors++; $display("FAIL single_data: got %h want 3ff0000000000000", bus.wb_data_o.rec); end
      checks++; if (bus.wb_rd_o !== 5'd3) begin errors++; $display("FAIL single_rd: got %0d want 3", bus.wb_rd_o); end
      bus.wb_yumi_i = 1'b1;
      tick();
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_after_yumi: got %b want 1", issue_ready_o); end
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL single_empty_after_yumi: got %b want 0", bus.wb_v_o); end
   endtask

   task automatic test_two_in_order();
      fflags_clr_i = 1'b1;
      tick();
      checks++; if (fflags_acc_o !== 5'b0) begin errors++; $display("FAIL acc_clear_alone: got %b want 0", fflags_acc_o); end
      issue_e = mk_entry(65'h111, 5'b00001, 5'd7);
      issue_v_i = 1'b1;
      tick();
      issue_e = mk_entry(65'h222, 5'b10000, 5'd9);
      issue_v_i = 1'b1;
      tick();
      for (int k = 2; k <= 5; k++) begin
         checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL two_ready_t%0d: got %b want 0", k, issue_ready_o); end
         tick();
      end
      checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL two_ready_t6: got %b want 0", issue_ready_o); end
      checks++; if (bus.wb_rd_o !== 5'd7 || bus.wb_v_o !== 1'b1)
         begin errors++; $display("FAIL two_head_first: got v=%b rd=%0d want v=1 rd=7", bus.wb_v_o, bus.wb_rd_o); end
      bus.wb_yumi_i = 1'b1;
      tick();
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL two_ready_after_yumi: got %b want 1", issue_ready_o); end
      checks++; if (bus.wb_rd_o !== 5'd9 || bus.wb_data_o.rec !== 65'h222 || bus.wb_v_o !== 1'b1)
         begin errors++; $display("FAIL two_head_second: got v=%b rd=%0d data=%h want v=1 rd=9 data=222", bus.wb_v_o, bus.wb_rd_o, bus.wb_data_o.rec); end
      bus.wb_yumi_i = 1'b1;
      tick();
      checks++; if (fflags_acc_o !== (acc_en_lp ? 5'b10001 : 5'b00000))
         begin errors++; $display("FAIL acc_sticky: got %b want %b", fflags_acc_o, acc_en_lp ? 5'b10001 : 5'b00000); end
   endtask

   task automatic test_simultaneous();
      issue_e = mk_entry(65'hA0A0, 5'b00100, 5'd1);
      issue_v_i = 1'b1;
      tick();
      issue_e = mk_entry(65'hB0B0, 5'b01000, 5'd2);
      issue_v_i = 1'b1;
      tick();
      tick(); tick(); tick();
      checks++; if (bus.wb_v_o !== 1'b1 || bus.wb_rd_o !== 5'd1)
         begin errors++; $display("FAIL simul_head_a: got v=%b rd=%0d want v=1 rd=1", bus.wb_v_o, bus.wb_rd_o); end
      bus.wb_yumi_i = 1'b1;
      fflags_clr_i  = 1'b1;
      tick();
      checks++; if (bus.wb_v_o !== 1'b1 || bus.wb_rd_o !== 5'd2 || bus.wb_data_o.rec !== 65'hB0B0)
         begin errors++; $display("FAIL simul_head_b: got v=%b rd=%0d data=%h want v=1 rd=2 data=b0b0", bus.wb_v_o, bus.wb_rd_o, bus.wb_data_o.rec); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b want 1", issue_ready_o); end
      checks++; if (fflags_acc_o !== (acc_en_lp ? 5'b00100 : 5'b00000))
         begin errors++; $display("FAIL acc_clr_with_deq: got %b want %b", fflags_acc_o, acc_en_lp ? 5'b00100 : 5'b00000); end
      bus.wb_yumi_i = 1'b1;
      tick();
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL simul_single_entry: got %b want 0", bus.wb_v_o); end
   endtask

   task automatic test_flush();
      logic [4:0] acc_before;
      issue_e = mk_entry(65'hC0C0, 5'b00010, 5'd4);
      issue_v_i = 1'b1;
      tick();
      tick(); tick(); tick(); tick();
      checks++; if (bus.wb_v_o !== 1'b1) begin errors++; $display("FAIL flush_pre_wb_v: got %b want 1", bus.wb_v_o); end
      issue_e = mk_entry(65'hD0D0, 5'b00010, 5'd5);
      issue_v_i = 1'b1;
      tick();
      acc_before = exp_acc();
      flush_i = 1'b1;
      tick();
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL flush_wb_v: got %b want 0", bus.wb_v_o); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", issue_ready_o); end
      checks++; if (fflags_acc_o !== acc_before) begin errors++; $display("FAIL flush_acc: got %b want %b", fflags_acc_o, acc_before); end
      tick(); tick(); tick();
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL flush_late_arrival: got %b want 0", bus.wb_v_o); end
   endtask

   task automatic test_reset_midstream();
      issue_e = mk_entry(65'hE0E0, 5'b00011, 5'd6);
      issue_v_i = 1'b1;
      tick();
      tick(); tick();
      issue_e = mk_entry(65'hF0F0, 5'b00011, 5'd8);
      issue_v_i = 1'b1;
      tick();
      tick();
      checks++; if (bus.wb_v_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_wb_v: got %b want 1", bus.wb_v_o); end
      #2 reset_n_i = 1'b0;
      model_kill();
      acc_exp = 5'b0;
      #1;
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL midrst_wb_v: got %b want 0", bus.wb_v_o); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", issue_ready_o); end
      checks++; if (fflags_acc_o !== 5'b0) begin errors++; $display("FAIL midrst_acc: got %b want 0", fflags_acc_o); end
      tick();
      reset_n_i = 1'b1;
      tick(); tick();
      checks++; if (bus.wb_v_o !== 1'b0) begin errors++; $display("FAIL midrst_late_arrival: got %b want 0", bus.wb_v_o); end
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", issue_ready_o); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bp_be_fma_wb_entry_s got;
         got = {bus.wb_data_o, bus.wb_fflags_o, bus.wb_rd_o};
         checks++; if (bus.wb_v_o !== (exp_q.size() != 0))
            begin errors++; $display("FAIL rand_wb_v cyc %0d: got %b want %b", cyc, bus.wb_v_o, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (got !== exp_q[0])
               begin errors++; $display("FAIL rand_head cyc %0d: got %h want %h", cyc, got, exp_q[0]); end
         end
         checks++; if (issue_ready_o !== exp_ready())
            begin errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, issue_ready_o, exp_ready()); end
         checks++; if (fflags_acc_o !== exp_acc())
            begin errors++; $display("FAIL rand_acc cyc %0d: got %b want %b", cyc, fflags_acc_o, exp_acc()); end
         issue_e       = rand_entry();
         issue_v_i     = exp_ready() && ($urandom_range(0, 2) != 0);
         flush_i       = ($urandom_range(0, 39) == 0);
         bus.wb_yumi_i = (exp_q.size() != 0) && ($urandom_range(0, 2) != 0);
         fflags_clr_i  = ($urandom_range(0, 15) == 0);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      acc_exp = 5'b0;
      issue_e = '0;
      issue_v_i = 1'b0;
      flush_i = 1'b0;
      fflags_clr_i = 1'b0;
      bus.fma_v_i = 1'b0;
      bus.fma_data_i = '0;
      bus.fma_fflags_i = '0;
      bus.fma_rd_i = '0;
      bus.wb_yumi_i = 1'b0;
      test_reset();
      test_single();
      test_two_in_order();
      test_simultaneous();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
